// File: rtl/tsc_mc_controller_pkg.sv
// Shared types and encodings for the TSC multicycle control unit: FSM states,
// instruction classes, opcode/func values and datapath mux select codes.
package tsc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } stateT;

  typedef enum logic [3:0] {
    CLS_BRANCH        = 4'd0,
    CLS_IMM_ALU       = 4'd1,
    CLS_R_ALU         = 4'd2,
    CLS_LOAD          = 4'd3,
    CLS_STORE         = 4'd4,
    CLS_JUMP          = 4'd5,
    CLS_LINK          = 4'd6,
    CLS_JUMP_REG      = 4'd7,
    CLS_JUMP_REG_LINK = 4'd8,
    CLS_WWD           = 4'd9,
    CLS_HLT           = 4'd10,
    CLS_ILLEGAL       = 4'd11
  } instClassT;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ALU_LAST = 6'd7;
  localparam logic [5:0] FN_JPR      = 6'd25;
  localparam logic [5:0] FN_JRL      = 6'd26;
  localparam logic [5:0] FN_WWD      = 6'd28;
  localparam logic [5:0] FN_HLT      = 6'd29;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  localparam logic [1:0] REGDST_98 = 2'd0;
  localparam logic [1:0] REGDST_76 = 2'd1;
  localparam logic [1:0] REGDST_R2 = 2'd2;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

  localparam logic [1:0] ALUB_REGB = 2'd0;
  localparam logic [1:0] ALUB_ONE  = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

  typedef struct packed {
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       iord;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] pcSource;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       outputActive;
    logic       illegal;
    logic       halted;
  } ctlT;

  // Classes that leave DECODE for the EXEC state rather than finishing there.
  function automatic logic needsExec(input instClassT cls);
    logic result;
    case (cls)
      CLS_BRANCH, CLS_IMM_ALU, CLS_R_ALU, CLS_LOAD, CLS_STORE: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tsc_mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the TSC
// datapath (slave): IR/flag/handshake inputs and every mux select and strobe.
interface tsc_mc_controller_if #(
  parameter int INST_W = 16,
  parameter int CNT_W  = 16
);
  logic [INST_W-1:0] inst;
  logic              mem_ready;
  logic              bcond;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              iord;
  logic              ir_write;
  logic              pc_write;
  logic              pc_write_cond;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        pc_source;
  logic [1:0]        reg_dst;
  logic [1:0]        mem_to_reg;
  logic              output_active;
  logic              illegal;
  logic              halted;
  logic [CNT_W-1:0]  num_inst;

  modport master (
    input  inst, mem_ready, bcond,
    output alu_src_a, alu_src_b, iord, ir_write, pc_write, pc_write_cond,
           reg_write, mem_read, mem_write, pc_source, reg_dst, mem_to_reg,
           output_active, illegal, halted, num_inst
  );

  modport slave (
    output inst, mem_ready, bcond,
    input  alu_src_a, alu_src_b, iord, ir_write, pc_write, pc_write_cond,
           reg_write, mem_read, mem_write, pc_source, reg_dst, mem_to_reg,
           output_active, illegal, halted, num_inst
  );
endinterface

// File: rtl/tsc_mc_controller_inst_decode.sv
// Combinational instruction classifier: maps opcode/func of the IR onto the
// small set of classes the control FSM dispatches on.
module tsc_inst_decode
  import tsc_ctrl_pkg::*;
#(
  parameter int INST_W = 16
) (
  input  logic [INST_W-1:0] inst,
  output instClassT         instClass
);

  logic [3:0] opcodeS;
  logic [5:0] funcS;
  logic       unusedMidBitsS;

  assign opcodeS        = inst[INST_W-1 -: 4];
  assign funcS          = inst[5:0];
  assign unusedMidBitsS = ^inst[INST_W-5:6];

  // Opcode first; R-type is further split by func.
  always_comb begin
    instClass = CLS_ILLEGAL;
    case (opcodeS)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: instClass = CLS_BRANCH;
      OP_ADI, OP_ORI, OP_LHI:         instClass = CLS_IMM_ALU;
      OP_LWD:                         instClass = CLS_LOAD;
      OP_SWD:                         instClass = CLS_STORE;
      OP_JMP:                         instClass = CLS_JUMP;
      OP_JAL:                         instClass = CLS_LINK;
      OP_RTYPE: begin
        if (funcS <= FN_ALU_LAST) begin
          instClass = CLS_R_ALU;
        end else begin
          case (funcS)
            FN_JPR:  instClass = CLS_JUMP_REG;
            FN_JRL:  instClass = CLS_JUMP_REG_LINK;
            FN_WWD:  instClass = CLS_WWD;
            FN_HLT:  instClass = CLS_HLT;
            default: instClass = CLS_ILLEGAL;
          endcase
        end
      end
      default: instClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/tsc_mc_controller.sv
// Multicycle control unit for the 16-bit TSC datapath: FETCH/DECODE/EXEC/MEM/
// WB/HALT sequencing with a mem_ready handshake and a retired-instruction count.
module tsc_mc_controller
  import tsc_ctrl_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int EX_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                reset_n,
  tsc_mc_controller_if.master bus
);

  localparam logic [3:0] EX_LAST = 4'(EX_CYCLES - 1);

  stateT            stateR;
  logic [3:0]       exCntR;
  logic [CNT_W-1:0] numInstR;
  instClassT        instClassS;
  logic             exLastS;
  ctlT              ctlS;

  tsc_inst_decode #(
    .INST_W (INST_W)
  ) uDecode (
    .inst      (bus.inst),
    .instClass (instClassS)
  );

  assign exLastS = (exCntR == EX_LAST);

  // State sequencing, EXEC dwell counter and retired-instruction count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateR   <= ST_FETCH;
      exCntR   <= 4'd0;
      numInstR <= '0;
    end else begin
      case (stateR)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            stateR <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (instClassS == CLS_HLT) begin
            stateR <= ST_HALT;
          end else if (needsExec(instClassS)) begin
            stateR <= ST_EXEC;
            exCntR <= 4'd0;
          end else begin
            stateR   <= ST_FETCH;
            numInstR <= numInstR + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (exLastS) begin
            case (instClassS)
              CLS_BRANCH: begin
                stateR   <= ST_FETCH;
                numInstR <= numInstR + CNT_W'(1);
              end
              CLS_LOAD, CLS_STORE: stateR <= ST_MEM;
              default:             stateR <= ST_WB;
            endcase
          end else begin
            exCntR <= exCntR + 4'd1;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            if (instClassS == CLS_STORE) begin
              stateR   <= ST_FETCH;
              numInstR <= numInstR + CNT_W'(1);
            end else begin
              stateR <= ST_WB;
            end
          end
        end
        ST_WB: begin
          stateR   <= ST_FETCH;
          numInstR <= numInstR + CNT_W'(1);
        end
        ST_HALT: stateR <= ST_HALT;
        default: stateR <= ST_FETCH;
      endcase
    end
  end

  // Mealy strobe decode; gated by reset_n so an asserted reset kills every
  // strobe in the same cycle, before the state register is even observed.
  always_comb begin
    ctlS = '0;
    if (!reset_n) begin
      ctlS = '0;
    end else begin
      case (stateR)
        ST_FETCH: begin
          ctlS.memRead = 1'b1;
          ctlS.iord    = 1'b0;
          if (bus.mem_ready) begin
            ctlS.irWrite  = 1'b1;
            ctlS.pcWrite  = 1'b1;
            ctlS.pcSource = PCSRC_ALU;
            ctlS.aluSrcA  = 1'b0;
            ctlS.aluSrcB  = ALUB_ONE;
          end else begin
            ctlS.aluSrcB = ALUB_REGB;
          end
        end
        ST_DECODE: begin
          ctlS.aluSrcA = 1'b0;
          ctlS.aluSrcB = ALUB_IMM;
          case (instClassS)
            CLS_JUMP: begin
              ctlS.pcWrite  = 1'b1;
              ctlS.pcSource = PCSRC_JUMP;
            end
            CLS_LINK: begin
              ctlS.pcWrite  = 1'b1;
              ctlS.pcSource = PCSRC_JUMP;
              ctlS.regWrite = 1'b1;
              ctlS.regDst   = REGDST_R2;
              ctlS.memToReg = MEMTOREG_PC;
            end
            CLS_JUMP_REG: begin
              ctlS.pcWrite  = 1'b1;
              ctlS.pcSource = PCSRC_REGA;
            end
            CLS_JUMP_REG_LINK: begin
              ctlS.pcWrite  = 1'b1;
              ctlS.pcSource = PCSRC_REGA;
              ctlS.regWrite = 1'b1;
              ctlS.regDst   = REGDST_R2;
              ctlS.memToReg = MEMTOREG_PC;
            end
            CLS_WWD:     ctlS.outputActive = 1'b1;
            CLS_ILLEGAL: ctlS.illegal      = 1'b1;
            default:     ctlS.illegal      = 1'b0;
          endcase
        end
        ST_EXEC: begin
          ctlS.aluSrcA = 1'b1;
          ctlS.aluSrcB = (instClassS == CLS_R_ALU) ? ALUB_REGB : ALUB_IMM;
          if (exLastS && (instClassS == CLS_BRANCH)) begin
            ctlS.pcWriteCond = 1'b1;
            ctlS.pcSource    = PCSRC_ALUOUT;
          end else begin
            ctlS.pcWriteCond = 1'b0;
          end
        end
        ST_MEM: begin
          ctlS.iord = 1'b1;
          if (instClassS == CLS_LOAD) begin
            ctlS.memRead = 1'b1;
          end else if (instClassS == CLS_STORE) begin
            ctlS.memWrite = 1'b1;
          end else begin
            ctlS.memRead = 1'b0;
          end
        end
        ST_WB: begin
          ctlS.regWrite = 1'b1;
          ctlS.regDst   = (instClassS == CLS_R_ALU) ? REGDST_76 : REGDST_98;
          ctlS.memToReg = (instClassS == CLS_LOAD) ? MEMTOREG_MDR : MEMTOREG_ALUOUT;
        end
        ST_HALT: ctlS.halted = 1'b1;
        default: ctlS = '0;
      endcase
    end
  end

  assign bus.alu_src_a     = ctlS.aluSrcA;
  assign bus.alu_src_b     = ctlS.aluSrcB;
  assign bus.iord          = ctlS.iord;
  assign bus.ir_write      = ctlS.irWrite;
  assign bus.pc_write      = ctlS.pcWrite;
  assign bus.pc_write_cond = ctlS.pcWriteCond;
  assign bus.reg_write     = ctlS.regWrite;
  assign bus.mem_read      = ctlS.memRead;
  assign bus.mem_write     = ctlS.memWrite;
  assign bus.pc_source     = ctlS.pcSource;
  assign bus.reg_dst       = ctlS.regDst;
  assign bus.mem_to_reg    = ctlS.memToReg;
  assign bus.output_active = ctlS.outputActive;
  assign bus.illegal       = ctlS.illegal;
  assign bus.halted        = ctlS.halted;
  assign bus.num_inst      = numInstR;

endmodule

// File: tb/tb_tsc_mc_controller.sv
// Directed bench for tsc_mc_controller: one EX_CYCLES=1 instance walks the
// instruction mix, an EX_CYCLES=3 instance checks the EXEC dwell on an ADD.
module tb_tsc_mc_controller;

  localparam logic [15:0] I_ADD   = 16'hF000;
  localparam logic [15:0] I_LWD   = 16'h7123;
  localparam logic [15:0] I_SWD   = 16'h8123;
  localparam logic [15:0] I_BEQ   = 16'h1004;
  localparam logic [15:0] I_JMP   = 16'h9010;
  localparam logic [15:0] I_JAL   = 16'hA010;
  localparam logic [15:0] I_OP12  = 16'hC000;
  localparam logic [15:0] I_WWD   = 16'hF01C;
  localparam logic [15:0] I_JPR   = 16'hF019;
  localparam logic [15:0] I_BADFN = 16'hF020;
  localparam logic [15:0] I_HLT   = 16'hF01D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memReady;
  logic        bcond;
  logic [15:0] inst;
  logic [18:0] obs1;
  logic [18:0] obs2;
  int          errors = 0;
  int          checks = 0;

  logic [18:0] vRst, vFr, vFw, vDec, vDecJal, vDecJmp, vDecJpr, vDecIll, vDecWwd;
  logic [18:0] vExR, vExI, vExBr, vMemLd, vMemSt, vWbR, vWbLd, vHalt;

  tsc_mc_controller_if #(.INST_W(16), .CNT_W(16)) bus1 ();
  tsc_mc_controller_if #(.INST_W(16), .CNT_W(16)) bus2 ();

  assign bus1.inst      = inst;
  assign bus1.mem_ready = memReady;
  assign bus1.bcond     = bcond;
  assign bus2.inst      = I_ADD;
  assign bus2.mem_ready = memReady;
  assign bus2.bcond     = bcond;

  tsc_mc_controller #(.INST_W(16), .EX_CYCLES(1), .CNT_W(16)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  tsc_mc_controller #(.INST_W(16), .EX_CYCLES(3), .CNT_W(16)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  assign obs1 = {bus1.alu_src_a, bus1.alu_src_b, bus1.iord, bus1.ir_write, bus1.pc_write,
                 bus1.pc_write_cond, bus1.reg_write, bus1.mem_read, bus1.mem_write,
                 bus1.pc_source, bus1.reg_dst, bus1.mem_to_reg, bus1.output_active,
                 bus1.illegal, bus1.halted};
  assign obs2 = {bus2.alu_src_a, bus2.alu_src_b, bus2.iord, bus2.ir_write, bus2.pc_write,
                 bus2.pc_write_cond, bus2.reg_write, bus2.mem_read, bus2.mem_write,
                 bus2.pc_source, bus2.reg_dst, bus2.mem_to_reg, bus2.output_active,
                 bus2.illegal, bus2.halted};

  always #5 clk = ~clk;

  // Field order: alu_src_a, alu_src_b, iord, ir_write, pc_write, pc_write_cond,
  // reg_write, mem_read, mem_write, pc_source, reg_dst, mem_to_reg, output_active,
  // illegal, halted.
  function automatic logic [18:0] ctl(input int asa, input int asb, input int io,
                                      input int irw, input int pcw, input int pcwc,
                                      input int rw, input int mr, input int mw,
                                      input int pcs, input int rd, input int m2r,
                                      input int oa, input int ill, input int hl);
    return {asa[0], asb[1:0], io[0], irw[0], pcw[0], pcwc[0], rw[0], mr[0], mw[0],
            pcs[1:0], rd[1:0], m2r[1:0], oa[0], ill[0], hl[0]};
  endfunction

  task automatic cv(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: strobes observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  task automatic cn(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: num_inst observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, check once settled.
  task automatic cyc(input string tag, input logic rn, input logic mr, input logic bc,
                     input logic [15:0] in, input logic [18:0] ev, input logic [15:0] en);
    @(negedge clk);
    reset_n  = rn;
    memReady = mr;
    bcond    = bc;
    inst     = in;
    #1;
    cv(tag, obs1, ev);
    cn({tag, "_n"}, bus1.num_inst, en);
  endtask

  initial begin
    vRst    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vFr     = ctl(0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vFw     = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vDec    = ctl(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vDecJal = ctl(0, 2, 0, 0, 1, 0, 1, 0, 0, 2, 2, 2, 0, 0, 0);
    vDecJmp = ctl(0, 2, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    vDecJpr = ctl(0, 2, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    vDecIll = ctl(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vDecWwd = ctl(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vExR    = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vExI    = ctl(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vExBr   = ctl(1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vMemLd  = ctl(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vMemSt  = ctl(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vWbR    = ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    vWbLd   = ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vHalt   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    reset_n  = 1'b1;
    memReady = 1'b1;
    bcond    = 1'b0;
    inst     = I_ADD;
    #2 reset_n = 1'b0;

    // Reset: everything quiet even with mem_ready high in FETCH.
    cyc("rst", 1'b0, 1'b1, 1'b0, I_ADD, vRst, 16'd0);
    cv("rst2", obs2, vRst);
    cn("rst2_n", bus2.num_inst, 16'd0);

    // ADD: F/D/X/WB on dut1; dut2 dwells three cycles in EXEC.
    cyc("add_f",  1'b1, 1'b1, 1'b0, I_ADD, vFr,  16'd0);  cv("add2_f",  obs2, vFr);
    cyc("add_d",  1'b1, 1'b1, 1'b0, I_ADD, vDec, 16'd0);  cv("add2_d",  obs2, vDec);
    cyc("add_x",  1'b1, 1'b1, 1'b0, I_ADD, vExR, 16'd0);  cv("add2_x0", obs2, vExR);
    cyc("add_wb", 1'b1, 1'b1, 1'b0, I_ADD, vWbR, 16'd0);  cv("add2_x1", obs2, vExR);

    // LWD with mem_ready low three cycles in MEM.
    cyc("lwd_f",  1'b1, 1'b1, 1'b0, I_LWD, vFr,    16'd1); cv("add2_x2", obs2, vExR);
    cyc("lwd_d",  1'b1, 1'b1, 1'b0, I_LWD, vDec,   16'd1); cv("add2_wb", obs2, vWbR);
    cyc("lwd_x",  1'b1, 1'b1, 1'b0, I_LWD, vExI,   16'd1); cv("add2_f2", obs2, vFr);
    cn("add2_n", bus2.num_inst, 16'd1);
    cyc("lwd_m0", 1'b1, 1'b0, 1'b0, I_LWD, vMemLd, 16'd1);
    cyc("lwd_m1", 1'b1, 1'b0, 1'b0, I_LWD, vMemLd, 16'd1);
    cyc("lwd_m2", 1'b1, 1'b0, 1'b0, I_LWD, vMemLd, 16'd1);
    cyc("lwd_m3", 1'b1, 1'b1, 1'b0, I_LWD, vMemLd, 16'd1);
    cyc("lwd_wb", 1'b1, 1'b1, 1'b0, I_LWD, vWbLd,  16'd1);

    // BEQ twice, with a fetch stall first; same EXEC strobes regardless of bcond.
    cyc("beq_fw", 1'b1, 1'b0, 1'b0, I_BEQ, vFw,   16'd2);
    cyc("beq_f",  1'b1, 1'b1, 1'b0, I_BEQ, vFr,   16'd2);
    cyc("beq_d",  1'b1, 1'b1, 1'b0, I_BEQ, vDec,  16'd2);
    cyc("beq_x0", 1'b1, 1'b1, 1'b0, I_BEQ, vExBr, 16'd2);
    cyc("beq_f2", 1'b1, 1'b1, 1'b0, I_BEQ, vFr,   16'd3);
    cyc("beq_d2", 1'b1, 1'b1, 1'b1, I_BEQ, vDec,  16'd3);
    cyc("beq_x1", 1'b1, 1'b1, 1'b1, I_BEQ, vExBr, 16'd3);

    // Two-cycle instructions resolved in DECODE, including illegal encodings.
    cyc("jal_f",   1'b1, 1'b1, 1'b0, I_JAL,   vFr,     16'd4);
    cyc("jal_d",   1'b1, 1'b1, 1'b0, I_JAL,   vDecJal, 16'd4);
    cyc("op12_f",  1'b1, 1'b1, 1'b0, I_OP12,  vFr,     16'd5);
    cyc("op12_d",  1'b1, 1'b1, 1'b0, I_OP12,  vDecIll, 16'd5);
    cyc("wwd_f",   1'b1, 1'b1, 1'b0, I_WWD,   vFr,     16'd6);
    cyc("wwd_d",   1'b1, 1'b1, 1'b0, I_WWD,   vDecWwd, 16'd6);
    cyc("jpr_f",   1'b1, 1'b1, 1'b0, I_JPR,   vFr,     16'd7);
    cyc("jpr_d",   1'b1, 1'b1, 1'b0, I_JPR,   vDecJpr, 16'd7);
    cyc("badfn_f", 1'b1, 1'b1, 1'b0, I_BADFN, vFr,     16'd8);
    cyc("badfn_d", 1'b1, 1'b1, 1'b0, I_BADFN, vDecIll, 16'd8);

    // HLT: parked for 20 cycles with mem_ready toggling, count frozen.
    cyc("hlt_f", 1'b1, 1'b1, 1'b0, I_HLT, vFr,  16'd9);
    cyc("hlt_d", 1'b1, 1'b1, 1'b0, I_HLT, vDec, 16'd9);
    for (int i = 0; i < 20; i++) begin
      cyc("halt", 1'b1, ((i % 2) == 1), 1'b0, I_HLT, vHalt, 16'd9);
    end

    // Reset out of HALT, then a JMP and a SWD killed by reset while in MEM.
    cyc("rst_b",   1'b0, 1'b1, 1'b0, I_JMP, vRst,    16'd0);
    cyc("jmp_f",   1'b1, 1'b1, 1'b0, I_JMP, vFr,     16'd0);
    cyc("jmp_d",   1'b1, 1'b1, 1'b0, I_JMP, vDecJmp, 16'd0);
    cyc("swd_f",   1'b1, 1'b1, 1'b0, I_SWD, vFr,     16'd1);
    cyc("swd_d",   1'b1, 1'b1, 1'b0, I_SWD, vDec,    16'd1);
    cyc("swd_x",   1'b1, 1'b1, 1'b0, I_SWD, vExI,    16'd1);
    cyc("swd_m",   1'b1, 1'b0, 1'b0, I_SWD, vMemSt,  16'd1);
    cyc("swd_rst", 1'b0, 1'b0, 1'b0, I_SWD, vRst,    16'd0);
    cyc("swd_rf",  1'b1, 1'b1, 1'b0, I_SWD, vFr,     16'd0);
    cyc("swd_rd",  1'b1, 1'b1, 1'b0, I_SWD, vDec,    16'd0);
    cyc("swd_x2",  1'b1, 1'b1, 1'b0, I_SWD, vExI,    16'd0);
    cyc("swd_m2",  1'b1, 1'b1, 1'b0, I_SWD, vMemSt,  16'd0);
    cyc("next_f",  1'b1, 1'b1, 1'b0, I_JMP, vFr,     16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tsc_mc_controller.md
# tsc_mc_controller

Parametrised multicycle control unit for the 16-bit TSC datapath. It replaces fixed-length fetch and memory sequences with a `mem_ready` handshake, and it adds a configurable ALU latency, full jump/link/halt/WWD decode, illegal-opcode flagging and a retired-instruction counter. It sits between the instruction register/ALU flags and every datapath mux and write strobe.

## Interface
- `INST_W`, 16, instruction width. Opcode is `inst[INST_W-1:INST_W-4]`; func is `inst[5:0]`.
- `EX_CYCLES`, 1, cycles spent in EXEC. Must be 1–15.
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`, in, 1, single clock.
- `reset_n`, in, 1, asynchronous, active-low.
- `inst`, in, `INST_W`, current instruction register contents.
- `mem_ready`, in, 1, memory has completed the current read/write this cycle.
- `bcond`, in, 1, ALU branch condition.
- `alu_src_a`, out, 1. 0 = PC, 1 = register A.
- `alu_src_b`, out, 2. 0 = register B, 1 = const 1, 2 = sign-extended imm.
- `iord`, out, 1. 0 = PC address, 1 = ALU-out address.
- `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`, `mem_read`, `mem_write`, out, 1 each, strobes.
- `pc_source`, out, 2. 0 = ALU, 1 = ALU-out (branch target), 2 = jump target, 3 = register A.
- `reg_dst`, out, 2. 0 = `inst[9:8]`, 1 = `inst[7:6]`, 2 = reg 2.
- `mem_to_reg`, out, 2. 0 = ALU-out, 1 = MDR, 2 = PC.
- `output_active`, out, 1, one-cycle pulse for WWD.
- `illegal`, out, 1, one-cycle pulse for an undefined opcode or func.
- `halted`, out, 1, high while in HALT.
- `num_inst`, out, `CNT_W`, retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- While `reset_n` is low: state = FETCH, EXEC counter = 0, `num_inst` = 0, and all outputs are forced to 0.
- **FETCH:** `mem_read`=1, `iord`=0.
  - Stays in FETCH while `mem_ready`=0.
  - In the cycle `mem_ready`=1, also asserts `ir_write`, `pc_write`, `pc_source`=0, `alu_src_a`=0, `alu_src_b`=1 (PC+1), then goes to DECODE.
- **DECODE:** register read; ALU computes the branch target (`alu_src_a`=0, `alu_src_b`=2). Dispatch:
  - JMP (9): `pc_write`, `pc_source`=2 → FETCH.
  - JAL (10): as JMP, plus `reg_write`, `reg_dst`=2, `mem_to_reg`=2 → FETCH.
  - R-type (15), by func:
    - JPR (25): `pc_write`, `pc_source`=3 → FETCH.
    - JRL (26): as JPR, plus the JAL link write → FETCH.
    - WWD (28): `output_active` → FETCH.
    - HLT (29): → HALT.
    - ALU funcs (0–7): → EXEC.
    - Any other func: `illegal` → FETCH.
  - Opcodes 0–8: → EXEC.
  - Opcodes 11–14: `illegal` → FETCH.
- **EXEC:** `alu_src_a`=1. `alu_src_b` is 0 for R-type, 2 otherwise.
  - Stays EX_CYCLES cycles, counted by an internal counter.
  - Last cycle:
    - Branches (0–3): `pc_write_cond`, `pc_source`=1 → FETCH.
    - ADI/ORI/LHI (4–6) and R-ALU: → WB.
    - LWD/SWD (7/8): → MEM.
- **MEM:** `iord`=1, with `mem_read` (LWD) or `mem_write` (SWD) held until `mem_ready`.
  - On ready: SWD → FETCH; LWD → WB.
- **WB:** `reg_write`=1. `reg_dst`=1 for R-type, 0 otherwise. `mem_to_reg`=1 for LWD, 0 otherwise. → FETCH.
- **HALT:** all strobes 0, `halted`=1. Exits only by reset. `mem_ready` is ignored.
- `num_inst` increments by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB, including illegal instructions. It wraps modulo 2^CNT_W. HALT is not counted.

## Timing
- Strobes are a combinational function of the state, the registered `inst`, `mem_ready` and `bcond` (Mealy on `mem_ready`). The state and counters are registered.
- Minimum CPI, with `mem_ready` tied high:
  - JMP/JAL/JPR/JRL/WWD: 2.
  - Branch: 2+EX_CYCLES.
  - ALU: 3+EX_CYCLES.
  - SWD: 3+EX_CYCLES.
  - LWD: 4+EX_CYCLES.
- Each cycle `mem_ready` stays low in FETCH/MEM adds exactly one cycle.
- `mem_ready` outside FETCH/MEM is ignored.
- `mem_read`/`mem_write` never assert together. `ir_write` fires only in the FETCH ready cycle.
- Reset asserted mid-instruction immediately kills all strobes. After release, the first FETCH begins on the next edge; no partial write completes.

## Structure
- Package `tsc_ctrl_pkg` holds:
  - the state enum;
  - opcode and func constants;
  - the `pc_source`/`reg_dst`/`mem_to_reg`/`alu_src_b` encodings.
- Sub-module `tsc_inst_decode` is a combinational classifier from `inst` to a class (branch, imm-ALU, R-ALU, load, store, jump, link, jump-reg, WWD, HLT, illegal). The FSM consumes only the class.

## Test plan
- ADD R-type, `mem_ready`=1, EX_CYCLES=1 → FETCH/DECODE/EXEC/WB; `reg_write`=1 in cycle 4 with `reg_dst`=1; `num_inst` 0→1.
- LWD with `mem_ready` low 3 cycles in MEM → MEM lasts 4 cycles with `iord`=1, `mem_read`=1, then WB with `mem_to_reg`=1; CPI=8.
- BEQ with `bcond`=0, then `bcond`=1 → `pc_write_cond`=1, `pc_source`=1 in the EXEC last cycle both times; no `reg_write`.
- JAL, then opcode 12 → JAL: `pc_write`, `reg_write`, `reg_dst`=2, `mem_to_reg`=2 in DECODE; opcode 12: `illegal` pulse; `num_inst` +2.
- HLT → `halted`=1 and all strobes 0 for 20 cycles with `mem_ready` toggling; `num_inst` unchanged.
- `reset_n` low during a SWD in MEM → `mem_write` drops the same cycle; after release, FETCH with `num_inst`=0.
